// File: rtl/dice_pkg.sv
// Shared definitions for the dice roll sequencer and the BCD counter datapath:
// die codes, sequencer state encoding and the max-face table.
package dice_pkg;

  localparam logic [2:0] DIE_D4   = 3'd0;
  localparam logic [2:0] DIE_D6   = 3'd1;
  localparam logic [2:0] DIE_D8   = 3'd2;
  localparam logic [2:0] DIE_D10  = 3'd3;
  localparam logic [2:0] DIE_D20  = 3'd4;
  localparam logic [2:0] DIE_D100 = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SPIN  = 2'd1,
    ST_COAST = 2'd2,
    ST_SHOW  = 2'd3
  } state_t;

  localparam logic [6:0] DIE_MAX [6] = '{7'd4, 7'd6, 7'd8, 7'd10, 7'd20, 7'd100};

  // Codes 6 and 7 are never produced; they map to the smallest die.
  function automatic logic [6:0] die_max(input logic [2:0] code);
    logic [6:0] face;
    case (code)
      DIE_D4:   face = DIE_MAX[0];
      DIE_D6:   face = DIE_MAX[1];
      DIE_D8:   face = DIE_MAX[2];
      DIE_D10:  face = DIE_MAX[3];
      DIE_D20:  face = DIE_MAX[4];
      DIE_D100: face = DIE_MAX[5];
      default:  face = DIE_MAX[0];
    endcase
    return face;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: multi-flop synchroniser, stable-count debouncer and a
// single-cycle rising-edge press pulse aligned with the debounced level change.
module btn_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 327
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic [CW-1:0]          cnt_r;
  logic                   level_r;
  logic                   press_r;
  logic                   sync_s;
  logic                   differ_s;
  logic                   flip_s;

  assign sync_s   = sync_r[SYNC_STAGES-1];
  assign differ_s = (sync_s != level_r);
  assign flip_s   = differ_s && (cnt_r == CW'(DEB_CYCLES - 1));

  // synchroniser chain, stable counter, level and press registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r  <= '0;
      cnt_r   <= '0;
      level_r <= 1'b0;
      press_r <= 1'b0;
    end else begin
      sync_r <= (sync_r << 1) | SYNC_STAGES'(raw);
      if (flip_s) begin
        cnt_r   <= '0;
        level_r <= sync_s;
      end else if (differ_s) begin
        cnt_r <= cnt_r + CW'(1);
      end else begin
        cnt_r <= '0;
      end
      press_r <= flip_s && sync_s;
    end
  end

  assign level = level_r;
  assign press = press_r;

endmodule

// File: rtl/dice_roll_ctrl.sv
// Roll sequencer: debounces the die-select buttons, picks the lowest pressed die,
// and drives the BCD counter with load/step pulses for spin, coast and show.
module dice_roll_ctrl
  import dice_pkg::*;
#(
  parameter int NBTN        = 6,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 327,
  parameter int COAST_BASE  = 512,
  parameter int COAST_STEPS = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ena,
  input  logic [NBTN-1:0] btn,
  output logic [2:0]      die_code,
  output logic            cnt_load,
  output logic            cnt_step,
  output logic            rolling,
  output logic            result_valid
);

  localparam int TW = $clog2(COAST_STEPS * COAST_BASE);
  localparam int KW = $clog2(COAST_STEPS + 1);

  logic [NBTN-1:0] deb_level_s;
  logic [NBTN-1:0] press_s;

  state_t          state_r;
  state_t          state_nxt;
  logic [2:0]      die_code_r;
  logic [2:0]      die_nxt;
  logic [TW-1:0]   timer_r;
  logic [TW-1:0]   timer_nxt;
  logic [KW-1:0]   k_r;
  logic [KW-1:0]   k_nxt;
  logic            cnt_load_r;
  logic            load_nxt;
  logic            cnt_step_r;
  logic            step_nxt;
  logic            rolling_r;
  logic            rolling_nxt;
  logic            result_valid_r;
  logic            valid_nxt;

  logic [2:0]      pick_s;
  logic            any_press_s;
  logic            hold_s;
  logic [31:0]     limit_s;
  logic            interval_done_s;
  logic            last_step_s;

  for (genvar g = 0; g < NBTN; g++) begin : g_btn
    btn_debounce #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEB_CYCLES  (DEB_CYCLES)
    ) u_deb (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn[g]),
      .level (deb_level_s[g]),
      .press (press_s[g])
    );
  end

  // lowest pressed index wins when several presses land on the same cycle
  always_comb begin
    pick_s = DIE_D4;
    for (int i = NBTN - 1; i >= 0; i--) begin
      pick_s = press_s[i] ? 3'(i) : pick_s;
    end
  end

  assign any_press_s     = |press_s;
  assign hold_s          = deb_level_s[die_code_r];
  assign limit_s         = 32'(k_r) * 32'(COAST_BASE) - 32'd1;
  assign interval_done_s = (32'(timer_r) == limit_s);
  assign last_step_s     = (k_r == KW'(COAST_STEPS));

  // state, timer, selection and registered outputs; ena low freezes all but pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      die_code_r     <= DIE_D4;
      timer_r        <= '0;
      k_r            <= '0;
      cnt_load_r     <= 1'b0;
      cnt_step_r     <= 1'b0;
      rolling_r      <= 1'b0;
      result_valid_r <= 1'b0;
    end else if (ena) begin
      state_r        <= state_nxt;
      die_code_r     <= die_nxt;
      timer_r        <= timer_nxt;
      k_r            <= k_nxt;
      cnt_load_r     <= load_nxt;
      cnt_step_r     <= step_nxt;
      rolling_r      <= rolling_nxt;
      result_valid_r <= valid_nxt;
    end else begin
      cnt_load_r <= 1'b0;
      cnt_step_r <= 1'b0;
    end
  end

  // next-state decision
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_IDLE:  state_nxt = any_press_s ? ST_SPIN : ST_IDLE;
      ST_SHOW:  state_nxt = any_press_s ? ST_SPIN : ST_SHOW;
      ST_SPIN:  state_nxt = hold_s ? ST_SPIN : ST_COAST;
      ST_COAST: state_nxt = (interval_done_s && last_step_s) ? ST_SHOW : ST_COAST;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // pulse, timer and selection updates; the load cycle itself never steps
  always_comb begin
    die_nxt   = die_code_r;
    load_nxt  = 1'b0;
    step_nxt  = 1'b0;
    timer_nxt = timer_r;
    k_nxt     = k_r;
    case (state_r)
      ST_IDLE, ST_SHOW: begin
        if (any_press_s) begin
          die_nxt  = pick_s;
          load_nxt = 1'b1;
        end else begin
          die_nxt  = die_code_r;
          load_nxt = 1'b0;
        end
      end
      ST_SPIN: begin
        if (hold_s) begin
          step_nxt = 1'b1;
        end else begin
          timer_nxt = '0;
          k_nxt     = KW'(1);
        end
      end
      ST_COAST: begin
        if (interval_done_s) begin
          step_nxt  = 1'b1;
          timer_nxt = '0;
          k_nxt     = last_step_s ? k_r : k_r + KW'(1);
        end else begin
          timer_nxt = timer_r + TW'(1);
        end
      end
      default: begin
        die_nxt = DIE_D4;
      end
    endcase
    rolling_nxt = (state_nxt == ST_SPIN) || (state_nxt == ST_COAST);
    valid_nxt   = (state_nxt == ST_SHOW);
  end

  assign die_code     = die_code_r;
  assign cnt_load     = cnt_load_r;
  assign cnt_step     = cnt_step_r;
  assign rolling      = rolling_r;
  assign result_valid = result_valid_r;

endmodule

// File: tb/tb_dice_roll_ctrl.sv
// Scoreboard bench for dice_roll_ctrl: every load/step pulse is predicted with its
// exact cycle and die code when the button stimulus is applied.
module tb_dice_roll_ctrl;

  localparam int SYNC  = 2;
  localparam int DEB   = 4;
  localparam int CBASE = 2;
  localparam int CSTEP = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [5:0] btn;
  logic [2:0] die_code;
  logic       cnt_load;
  logic       cnt_step;
  logic       rolling;
  logic       result_valid;

  logic [31:0] cyc = 32'd0;
  logic [31:0] sb_q[$];
  int n_vec = 0;
  int n_err = 0;

  dice_roll_ctrl #(
    .NBTN        (6),
    .SYNC_STAGES (SYNC),
    .DEB_CYCLES  (DEB),
    .COAST_BASE  (CBASE),
    .COAST_STEPS (CSTEP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .btn          (btn),
    .die_code     (die_code),
    .cnt_load     (cnt_load),
    .cnt_step     (cnt_step),
    .rolling      (rolling),
    .result_valid (result_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", tag, cyc, obs, exp_v);
    end
  endtask

  // Pulse record: {step, load, die_code, cycle}
  always @(negedge clk) begin
    logic [31:0] obs;
    logic [31:0] exp_v;
    if (cnt_load === 1'b1 || cnt_step === 1'b1) begin
      obs = {cnt_step, cnt_load, die_code, cyc[26:0]};
      if (sb_q.size() == 0) begin
        chk("unexpected_pulse", obs, 32'd0);
      end else begin
        exp_v = sb_q.pop_front();
        chk("pulse", obs, exp_v);
      end
    end
  end

  task automatic wait_until(input int target);
    while (int'(cyc) < target) @(negedge clk);
  endtask

  // Press applied at negedge n, released at negedge r; steps in [skip_lo, skip_hi] are suppressed.
  task automatic expect_roll(input logic [2:0] die, input int n, input int r, input int ncoast,
                             input int skip_lo, input int skip_hi, output int show_at);
    int at;
    sb_q.push_back({2'b01, die, 27'(n + SYNC + DEB + 1)});
    for (int e = n + SYNC + DEB + 2; e <= r + SYNC + DEB; e++) begin
      if (e < skip_lo || e > skip_hi) sb_q.push_back({2'b10, die, 27'(e)});
    end
    at = r + SYNC + DEB + 1;
    for (int k = 1; k <= CSTEP; k++) begin
      at = at + k * CBASE;
      if (k <= ncoast) sb_q.push_back({2'b10, die, 27'(at)});
    end
    show_at = at;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int show;
    rst = 1'b1;
    ena = 1'b1;
    btn = 6'h3F;
    repeat (3) @(negedge clk);
    chk("rst_die", 32'(die_code), 32'd0);
    chk("rst_load", 32'(cnt_load), 32'd0);
    chk("rst_step", 32'(cnt_step), 32'd0);
    chk("rst_rolling", 32'(rolling), 32'd0);
    chk("rst_valid", 32'(result_valid), 32'd0);

    // buttons still held after reset: all qualify together, d4 wins
    rst = 1'b0;
    n = int'(cyc);
    expect_roll(3'd0, n, n + 12, CSTEP, 0, 0, show);
    wait_until(n + 6);
    chk("pre_press_rolling", 32'(rolling), 32'd0);
    wait_until(n + 7);
    chk("post_rst_rolling", 32'(rolling), 32'd1);
    wait_until(n + 12);
    btn = 6'h00;
    wait_until(show);
    chk("r0_valid", 32'(result_valid), 32'd1);
    chk("r0_rolling", 32'(rolling), 32'd0);
    chk("r0_die", 32'(die_code), 32'd0);

    // d20 from SHOW: result_valid drops together with the load
    wait_until(show + 10);
    n = int'(cyc);
    btn = 6'b010000;
    expect_roll(3'd4, n, n + 20, CSTEP, 0, 0, show);
    wait_until(n + 6);
    chk("r1_valid_before", 32'(result_valid), 32'd1);
    wait_until(n + 7);
    chk("r1_valid_at_load", 32'(result_valid), 32'd0);
    chk("r1_die", 32'(die_code), 32'd4);
    wait_until(n + 20);
    btn = 6'h00;
    wait_until(show);
    chk("r1_valid", 32'(result_valid), 32'd1);

    // simultaneous d6+d10: d6 wins, d10 held longer has no effect
    wait_until(show + 10);
    n = int'(cyc);
    btn = 6'b001010;
    expect_roll(3'd1, n, n + 10, CSTEP, 0, 0, show);
    wait_until(n + 10);
    btn = 6'b001000;
    wait_until(n + 20);
    btn = 6'h00;
    wait_until(show);
    chk("r2_die", 32'(die_code), 32'd1);
    chk("r2_valid", 32'(result_valid), 32'd1);

    // bouncing d8 never qualifies
    wait_until(show + 10);
    n = int'(cyc);
    btn = 6'b000100;
    wait_until(n + 3);
    btn = 6'h00;
    wait_until(n + 4);
    btn = 6'b000100;
    wait_until(n + 7);
    btn = 6'h00;
    wait_until(n + 20);
    chk("bounce_valid", 32'(result_valid), 32'd1);
    chk("bounce_die", 32'(die_code), 32'd1);
    n = int'(cyc);
    btn = 6'b000100;
    expect_roll(3'd2, n, n + 8, CSTEP, 0, 0, show);
    wait_until(n + 8);
    btn = 6'h00;
    wait_until(show);
    chk("r3_die", 32'(die_code), 32'd2);

    // d100 from SHOW, with a full d4 press landing during COAST
    wait_until(show + 10);
    n = int'(cyc);
    btn = 6'b100000;
    expect_roll(3'd5, n, n + 8, CSTEP, 0, 0, show);
    wait_until(n + 7);
    chk("r4_valid_at_load", 32'(result_valid), 32'd0);
    chk("r4_die", 32'(die_code), 32'd5);
    wait_until(n + 8);
    btn = 6'h00;
    wait_until(n + 16);
    btn = 6'b000001;
    wait_until(n + 24);
    btn = 6'h00;
    wait_until(show);
    chk("r4_die_show", 32'(die_code), 32'd5);
    chk("r4_valid", 32'(result_valid), 32'd1);

    // reset after two coast steps: no third step, back to IDLE
    wait_until(show + 10);
    n = int'(cyc);
    btn = 6'b010000;
    expect_roll(3'd4, n, n + 8, 2, 0, 0, show);
    wait_until(n + 8);
    btn = 6'h00;
    wait_until(n + 22);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_coast_rolling", 32'(rolling), 32'd0);
    chk("rst_coast_valid", 32'(result_valid), 32'd0);
    chk("rst_coast_die", 32'(die_code), 32'd0);
    wait_until(n + 45);
    chk("rst_coast_idle", 32'(rolling), 32'd0);

    // ena low during SPIN: four edges with no pulse, then resume
    n = int'(cyc);
    btn = 6'b001000;
    expect_roll(3'd3, n, n + 20, CSTEP, n + 11, n + 14, show);
    wait_until(n + 10);
    ena = 1'b0;
    wait_until(n + 12);
    chk("ena_rolling", 32'(rolling), 32'd1);
    chk("ena_step", 32'(cnt_step), 32'd0);
    wait_until(n + 14);
    ena = 1'b1;
    wait_until(n + 20);
    btn = 6'h00;
    wait_until(show);
    chk("r6_valid", 32'(result_valid), 32'd1);
    chk("r6_die", 32'(die_code), 32'd3);

    wait_until(show + 10);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
